// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   MEM_ADDR_WIDTH  default word-address width of the data RAM
//   MASK_*          byte-mask encodings (bit3 = byte offset 0 ... bit0 = byte offset 3)
//   load_meta_t     request fields that travel alongside the registered RAM word
//   mask_is_legal   true for the masks a load or store may use
//   format_load     turns a registered RAM word into the writeback value
package dmem_resp_pkg;

  localparam int MEM_ADDR_WIDTH = 10;

  localparam logic [3:0] MASK_W  = 4'b1111;
  localparam logic [3:0] MASK_H0 = 4'b1100;
  localparam logic [3:0] MASK_H2 = 4'b0011;
  localparam logic [3:0] MASK_B0 = 4'b1000;
  localparam logic [3:0] MASK_B1 = 4'b0100;
  localparam logic [3:0] MASK_B2 = 4'b0010;
  localparam logic [3:0] MASK_B3 = 4'b0001;

  typedef struct packed {
    logic [3:0] mask;
    logic       sign_ext;
    logic [4:0] rd_addr;
  } load_meta_t;

  function automatic logic mask_is_legal(input logic [3:0] mask);
    logic ok;
    ok = 1'b0;
    case (mask)
      MASK_W, MASK_H0, MASK_H2, MASK_B0, MASK_B1, MASK_B2, MASK_B3: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The RAM keeps byte offset 0 in lane 3, so every field is byte-swapped
  // back into little-endian order before extension. An unknown mask
  // (only seen after reset) yields zero.
  function automatic logic [31:0] format_load(input logic [31:0] w,
                                              input logic [3:0]  mask,
                                              input logic        sign_ext);
    logic [31:0] result;
    logic [15:0] half;
    logic [7:0]  lane;
    result = '0;
    half   = '0;
    lane   = '0;
    case (mask)
      MASK_W:  result = {w[7:0], w[15:8], w[23:16], w[31:24]};
      MASK_H0: begin
        half   = {w[23:16], w[31:24]};
        result = {{16{sign_ext & half[15]}}, half};
      end
      MASK_H2: begin
        half   = {w[7:0], w[15:8]};
        result = {{16{sign_ext & half[15]}}, half};
      end
      MASK_B0, MASK_B1, MASK_B2, MASK_B3: begin
        case (mask)
          MASK_B0: lane = w[31:24];
          MASK_B1: lane = w[23:16];
          MASK_B2: lane = w[15:8];
          default: lane = w[7:0];
        endcase
        result = {{24{sign_ext & lane[7]}}, lane};
      end
      default: result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_resp_bram.sv
// Single-port, byte-enabled, word-addressed RAM with a registered read port.
//   clk     clock, rising edge
//   rst     async active-high reset of the read register only (contents persist)
//   re      read enable; the read register holds its value while low
//   be      byte write enables, be[i] writes w_data[8*i+7:8*i]
//   addr    word address, shared by read and write
//   w_data  write data
//   r_data  registered read data (old contents on a same-edge write)
module dmem_resp_bram
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       w_data,
  output logic [31:0]       r_data
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Storage array: no reset so it maps onto block RAM; each lane is
  // written only when its enable is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // Output register: samples the old word on a same-cycle write, and
  // holds while re is low so a stalled result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (re) begin
      r_data <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: commits masked stores, returns formatted load
// results with their rd tag under a valid/ready handshake (latency 1).
//   clk, rst        clock and async active-high reset
//   ram_we/ram_re   store / load request
//   ram_wr_addr     word address (wraps modulo the RAM depth)
//   ram_w_data      byte-swapped store data, lane 3 = byte offset 0
//   ram_wr_mask     byte mask, bit3 = offset 0 ... bit0 = offset 3
//   ram_r_sign_ext  sign-extend half/byte loads
//   rd_addr_i       destination tag of a load
//   req_ready       request accepted this cycle when high
//   load_valid, load_rd_addr, load_data   load result to writeback
//   wb_ready        writeback consumes the result
//   misalign_err    one-cycle pulse for an illegal mask or we&re request
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_we,
  input  logic              ram_re,
  input  logic [ADDR_W-1:0] ram_wr_addr,
  input  logic [31:0]       ram_w_data,
  input  logic [3:0]        ram_wr_mask,
  input  logic              ram_r_sign_ext,
  input  logic [4:0]        rd_addr_i,
  output logic              req_ready,
  output logic              load_valid,
  output logic [4:0]        load_rd_addr,
  output logic [31:0]       load_data,
  input  logic              wb_ready,
  output logic              misalign_err
);

  logic        accept;
  logic        legal;
  logic        do_read;
  logic        do_write;
  logic [3:0]  bram_be;
  logic [31:0] ram_word;
  load_meta_t  meta;

  // Request decode. A stalled result blocks every request; illegal
  // requests are still "accepted" so they raise the error pulse, but
  // neither touch the RAM nor produce a result.
  always_comb begin
    req_ready = !(load_valid && !wb_ready);
    accept    = req_ready && (ram_we || ram_re);
    legal     = mask_is_legal(ram_wr_mask) && !(ram_we && ram_re);
    do_read   = accept && legal && ram_re;
    do_write  = accept && legal && ram_we;
    bram_be   = do_write ? ram_wr_mask : 4'b0000;
  end

  dmem_resp_bram #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk    (clk),
    .rst    (rst),
    .re     (do_read),
    .be     (bram_be),
    .addr   (ram_wr_addr),
    .w_data (ram_w_data),
    .r_data (ram_word)
  );

  // Result pipeline: meta is captured with the RAM word, and load_valid
  // drops only when writeback takes the result with no new load behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_valid   <= 1'b0;
      meta         <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= accept && !legal;
      if (do_read) begin
        load_valid <= 1'b1;
        meta       <= '{mask: ram_wr_mask, sign_ext: ram_r_sign_ext, rd_addr: rd_addr_i};
      end else if (wb_ready) begin
        load_valid <= 1'b0;
      end
    end
  end

  assign load_rd_addr = meta.rd_addr;
  assign load_data    = format_load(ram_word, meta.mask, meta.sign_ext);

endmodule
